// File: rtl/mem_arbiter.sv
// Two-port mmu arbiter: data-over-fetch priority with a fetch starvation guard.
// Optional WAIT timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int STARVE_MAX     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fReq,
  input  logic [31:0] fAddr,
  output logic        fAck,
  output logic [31:0] fRdata,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dByteena,
  output logic        dAck,
  output logic [31:0] dRdata,
  output logic        mReq,
  output logic        mWe,
  output logic [31:0] mAddr,
  output logic [31:0] mWdata,
  output logic [3:0]  mByteena,
  input  logic        mDone,
  input  logic [31:0] mRdata,
  output logic        busy,
  output logic        timeoutErr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam bit TO_RANGE_OK =
    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);

  logic [1:0]  r_state;
  logic        r_own_d;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [3:0]  r_starve;
  logic [31:0] r_frdata;
  logic [31:0] r_drdata;

  logic w_force_f;
  logic w_grant_d;
  logic w_tout;

  // Fetch overrides data once it has lost STARVE_MAX times in a row
  assign w_force_f = (STARVE_MAX > 0) && fReq &&
                     (r_starve == 4'(STARVE_MAX));
  assign w_grant_d = dReq && !w_force_f;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic        r_terr;

  assign w_tout = TO_RANGE_OK && (r_state == S_WAIT) && !mDone &&
                  ((r_tcnt + 16'd1) == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_tcnt <= '0;
      else if (r_state == S_WAIT)
        r_tcnt <= r_tcnt + 16'd1;
      if (w_tout)
        r_terr <= 1'b1;
    end
  end

  assign timeoutErr = r_terr;
`else
  assign w_tout     = 1'b0 & TO_RANGE_OK;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_own_d  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_starve <= '0;
      r_frdata <= '0;
      r_drdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fReq || dReq) begin
            r_state <= S_ISSUE;
            r_own_d <= w_grant_d;
            r_we    <= w_grant_d && dWe;
            r_addr  <= w_grant_d ? dAddr : fAddr;
            r_wdata <= w_grant_d ? dWdata : 32'd0;
            r_be    <= w_grant_d ? dByteena : 4'hF;
            if (!w_grant_d)
              r_starve <= '0;
            else if (fReq && r_starve != 4'hF)
              r_starve <= r_starve + 4'd1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (mDone || w_tout) begin
            r_state <= S_RESP;
            if (r_own_d)
              r_drdata <= mDone ? mRdata : 32'hDEADBEEF;
            else
              r_frdata <= mDone ? mRdata : 32'hDEADBEEF;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mReq     = (r_state == S_ISSUE);
  assign mWe      = r_we;
  assign mAddr    = r_addr;
  assign mWdata   = r_wdata;
  assign mByteena = r_be;
  assign busy     = (r_state != S_IDLE);
  assign fAck     = (r_state == S_RESP) && !r_own_d;
  assign dAck     = (r_state == S_RESP) && r_own_d;
  assign fRdata   = r_frdata;
  assign dRdata   = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps, randomized traffic, grant/data model.
module tb_mem_arbiter;

  localparam int SM = 2;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        fReq = 1'b0;
  logic [31:0] fAddr = '0;
  logic        fAck;
  logic [31:0] fRdata;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [3:0]  dByteena = '0;
  logic        dAck;
  logic [31:0] dRdata;
  logic        mReq;
  logic        mWe;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [3:0]  mByteena;
  logic        mDone = 1'b0;
  logic [31:0] mRdata = '0;
  logic        busy;
  logic        timeoutErr;

  logic        z_fAck, z_dAck, z_mReq, z_mWe, z_busy, z_terr;
  logic [31:0] z_fRdata, z_dRdata, z_mAddr, z_mWdata;
  logic [3:0]  z_mBe;
  logic        z_mDone = 1'b0;
  int          z_fcnt = 0;
  int          z_dcnt = 0;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_frd = '0;
  logic [31:0] m_drd = '0;
  bit          m_dknown = 1'b1;
  int          m_lost = 0;

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT_CYCLES(TO)) u_dut (
    .CLK(CLK), .RST(RST),
    .fReq(fReq), .fAddr(fAddr), .fAck(fAck), .fRdata(fRdata),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dByteena(dByteena), .dAck(dAck), .dRdata(dRdata),
    .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWdata(mWdata),
    .mByteena(mByteena), .mDone(mDone), .mRdata(mRdata),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  // Pure data priority instance: both requesters always asserted
  mem_arbiter #(.STARVE_MAX(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .CLK(CLK), .RST(RST),
    .fReq(1'b1), .fAddr(32'h40), .fAck(z_fAck), .fRdata(z_fRdata),
    .dReq(1'b1), .dWe(1'b0), .dAddr(32'h80), .dWdata(32'd0),
    .dByteena(4'hF), .dAck(z_dAck), .dRdata(z_dRdata),
    .mReq(z_mReq), .mWe(z_mWe), .mAddr(z_mAddr), .mWdata(z_mWdata),
    .mByteena(z_mBe), .mDone(z_mDone), .mRdata(32'h1234),
    .busy(z_busy), .timeoutErr(z_terr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) z_mDone <= z_mReq;

  always @(negedge CLK) begin
    if (z_fAck) z_fcnt++;
    if (z_dAck) z_dcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner from the current request levels and the fetch loss count
  task automatic arb_expect(output bit win_d);
    win_d = dReq && !(fReq && SM > 0 && m_lost == SM);
    if (win_d && fReq)
      m_lost = (m_lost >= 15) ? 15 : m_lost + 1;
    else if (!win_d)
      m_lost = 0;
  endtask

  task automatic access(input bit is_d, input int lat,
                        input logic [31:0] rd, input bit spur,
                        output int busyc);
    logic [31:0] ea, ewd, erd;
    logic        ewe;
    logic [3:0]  ebe;
    int          n, nw;
    ea  = is_d ? dAddr : fAddr;
    ewe = is_d ? dWe : 1'b0;
    ebe = is_d ? dByteena : 4'hF;
    ewd = dWdata;
    n = 0;
    busyc = 0;
    while (mReq !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("mreq_start", mReq, 1);
    if (mReq !== 1'b1) return;
    chk("issue_addr", mAddr, ea);
    chk("issue_we", mWe, ewe);
    chk("issue_be", mByteena, ebe);
    if (ewe) chk("issue_wdata", mWdata, ewd);
    busyc += busy;
    if (spur) begin
      mDone = 1'b1;
      mRdata = ~rd;
    end
    @(negedge CLK);
    mDone = 1'b0;
    nw = (lat > 0) ? lat : TO;
    for (int k = 1; k <= nw; k++) begin
      chk("wait_mreq", mReq, 0);
      chk("wait_addr", mAddr, ea);
      chk("wait_ack", {fAck, dAck}, 0);
      busyc += busy;
      if (lat > 0 && k == lat) begin
        mDone = 1'b1;
        mRdata = rd;
      end
      @(negedge CLK);
      mDone = 1'b0;
    end
    erd = (lat > 0) ? rd : 32'hDEADBEEF;
    chk("resp_fack", fAck, !is_d);
    chk("resp_dack", dAck, is_d);
    busyc += busy;
    if (is_d) begin
      m_dknown = !ewe;
      m_drd = erd;
      dReq = 1'b0;
    end else begin
      m_frd = erd;
      fReq = 1'b0;
    end
    chk("resp_frdata", fRdata, m_frd);
    if (m_dknown) chk("resp_drdata", dRdata, m_drd);
    @(negedge CLK);
    busyc += busy;
    chk("idle_busy", busy, 0);
    chk("idle_ack", {fAck, dAck}, 0);
  endtask

  initial begin
    bit w;
    int bc;
    bit tbl [6];
    tbl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    #2 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_ctl", {mReq, mWe, fAck, dAck, busy, timeoutErr}, 0);
    chk("rst_maddr", mAddr, 0);
    chk("rst_mwdata", mWdata, 0);
    chk("rst_mbe", mByteena, 0);
    chk("rst_frdata", fRdata, 0);
    chk("rst_drdata", dRdata, 0);
    RST = 1'b0;
    @(negedge CLK);

    // fetch-only read, completion on third WAIT cycle
    fReq = 1'b1;
    fAddr = 32'h100;
    arb_expect(w);
    access(w, 3, 32'h00500093, 1'b0, bc);
    chk("fetch_busy_cycles", bc, 5);
    chk("fetch_rdata", fRdata, 32'h00500093);

    // simultaneous requests: store first, fetch after one IDLE
    fReq = 1'b1;
    fAddr = 32'h104;
    dReq = 1'b1;
    dWe = 1'b1;
    dAddr = 32'h2000;
    dWdata = 32'hCAFEBABE;
    dByteena = 4'h3;
    arb_expect(w);
    access(w, 1, 32'h0, 1'b0, bc);
    @(negedge CLK);
    chk("sim_gap_mreq", mReq, 1);
    chk("sim_fetch_addr", mAddr, 32'h104);
    arb_expect(w);
    access(w, 2, 32'h00000013, 1'b0, bc);

    // starvation guard, fetch held high, data re-requested each IDLE
    dWe = 1'b0;
    dByteena = 4'hF;
    fAddr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      fReq = 1'b1;
      if (!dReq) begin
        dReq = 1'b1;
        dAddr = 32'h3000 + 32'(i * 4);
      end
      arb_expect(w);
      access(tbl[i], 1, $urandom, 1'b0, bc);
    end
    dReq = 1'b0;
    fReq = 1'b0;
    @(negedge CLK);

    // spurious completions in IDLE and ISSUE
    mDone = 1'b1;
    mRdata = 32'h55AA55AA;
    @(negedge CLK);
    mDone = 1'b0;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_ack", {fAck, dAck}, 0);
    fReq = 1'b1;
    fAddr = 32'h300;
    arb_expect(w);
    access(w, 2, 32'h11112222, 1'b1, bc);

    // reset during WAIT of a data load
    dReq = 1'b1;
    dWe = 1'b0;
    dAddr = 32'h4000;
    for (int n = 0; n < 20 && mReq !== 1'b1; n++) @(negedge CLK);
    chk("rst_mid_mreq", mReq, 1);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_mid_inwait", busy, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_ctl", {mReq, mWe, fAck, dAck, busy, timeoutErr}, 0);
    chk("rst_mid_maddr", mAddr, 0);
    chk("rst_mid_rdata", fRdata | dRdata, 0);
    m_frd = '0;
    m_drd = '0;
    m_dknown = 1'b1;
    m_lost = 0;
    dReq = 1'b0;
    @(negedge CLK);
    chk("rst_mid_noack", dAck, 0);
    RST = 1'b0;
    @(negedge CLK);
    fReq = 1'b1;
    fAddr = 32'h0;
    arb_expect(w);
    access(w, 1, 32'h00000297, 1'b0, bc);

`ifdef MEM_ARB_TIMEOUT_EN
    dReq = 1'b1;
    dWe = 1'b0;
    dAddr = 32'h5000;
    arb_expect(w);
    access(w, 0, 32'h0, 1'b0, bc);
    chk("to_rdata", dRdata, 32'hDEADBEEF);
    chk("to_err", timeoutErr, 1);
    fReq = 1'b1;
    fAddr = 32'h500;
    arb_expect(w);
    access(w, 2, 32'h0badf00d, 1'b0, bc);
    chk("to_err_sticky", timeoutErr, 1);
    RST = 1'b1;
    #1;
    chk("to_err_rst", timeoutErr, 0);
    m_frd = '0;
    m_drd = '0;
    m_dknown = 1'b1;
    m_lost = 0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
`else
    chk("terr_tied", timeoutErr, 0);
`endif

    // randomized traffic against the grant/data model
    for (int i = 0; i < 30; i++) begin
      if (!fReq && $urandom_range(0, 1) == 1) begin
        fReq = 1'b1;
        fAddr = $urandom;
      end
      if (!dReq && $urandom_range(0, 1) == 1) begin
        dReq = 1'b1;
        dWe = 1'($urandom_range(0, 1));
        dAddr = $urandom;
        dWdata = $urandom;
        dByteena = 4'($urandom_range(1, 15));
      end
      if (!fReq && !dReq) begin
        fReq = 1'b1;
        fAddr = $urandom;
      end
      arb_expect(w);
      access(w, $urandom_range(1, 4), $urandom,
             $urandom_range(0, 3) == 0, bc);
    end
    fReq = 1'b0;
    dReq = 1'b0;
    repeat (3) @(negedge CLK);
    chk("end_idle", busy, 0);

    chk("sm0_no_fetch", z_fcnt, 0);
    chk("sm0_data_served", 32'(z_dcnt > 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
